emesh_fifo_arbiter: RTL and testbench

Arbitrates N emesh transaction sources onto the single write port of the asynchronous emesh FIFO. It runs entirely in the FIFO write-clock domain. It grants one requester per cycle, round-robin by default, and applies per-requester wait backpressure. Output is registered and throttled by the FIFO's programmable-full flag. It sits between on-chip emesh masters (e.g. read-request, write, and DMA channels) and the 104-bit async FIFO.

---
 rtl/emesh_pkg.sv | 46 ++++
 rtl/emesh_fifo_arbiter_arb_rr.sv | 52 +++++
 rtl/emesh_fifo_arbiter.sv | 133 +++++++++++++
 tb/tb_emesh_fifo_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/emesh_pkg.sv
// ----------------------------------------------------------------------------
// emesh_pkg
// Shared emesh packet definitions used by the FIFO arbiter and the async FIFO
// wrapper.
//   - EMESH_PW              : flat emesh packet width (104 bits)
//   - EMESH_*_BIT / *_LSB   : bit positions of each field in the flat packet
//   - emesh_packet_t        : packed packet struct; its layout matches the flat
//                             bit positions, so a cast in either direction is
//                             lossless
//   - emesh_unpack()        : flat vector -> struct using the named positions
// ----------------------------------------------------------------------------
package emesh_pkg;

   localparam int EMESH_PW           = 104;
   localparam int EMESH_ACCESS_BIT   = 0;
   localparam int EMESH_WRITE_BIT    = 1;
   localparam int EMESH_DATAMODE_LSB = 2;
   localparam int EMESH_CTRLMODE_LSB = 4;
   localparam int EMESH_DSTADDR_LSB  = 8;
   localparam int EMESH_DATA_LSB     = 40;
   localparam int EMESH_SRCADDR_LSB  = 72;

   // Declared MSB-first so that access lands on bit 0 of the packed vector.
   typedef struct packed {
      logic [31:0] srcaddr;
      logic [31:0] data;
      logic [31:0] dstaddr;
      logic [3:0]  ctrlmode;
      logic [1:0]  datamode;
      logic        write;
      logic        access;
   } emesh_packet_t;

   function automatic emesh_packet_t emesh_unpack(input logic [EMESH_PW-1:0] bits);
      emesh_packet_t p;
      p.access   = bits[EMESH_ACCESS_BIT];
      p.write    = bits[EMESH_WRITE_BIT];
      p.datamode = bits[EMESH_DATAMODE_LSB +: 2];
      p.ctrlmode = bits[EMESH_CTRLMODE_LSB +: 4];
      p.dstaddr  = bits[EMESH_DSTADDR_LSB  +: 32];
      p.data     = bits[EMESH_DATA_LSB     +: 32];
      p.srcaddr  = bits[EMESH_SRCADDR_LSB  +: 32];
      return p;
   endfunction

endpackage

// File: rtl/emesh_fifo_arbiter_arb_rr.sv
// ----------------------------------------------------------------------------
// arb_rr
// Purely combinational rotating-priority arbiter, reused by other emesh muxes.
// Grants the first set bit of elig found by searching upward from ptr and
// wrapping from N-1 back to 0. With ptr tied to zero it degenerates into a
// fixed lowest-index-wins arbiter.
//   N      : number of requesters (2..8)
//   elig   : in  [N-1:0]      eligible requesters
//   ptr    : in  [PTR_W-1:0]  highest-priority index, must be < N
//   grant  : out [N-1:0]      one-hot grant, or zero when elig is zero
// ----------------------------------------------------------------------------
module arb_rr
   import emesh_pkg::*;
#(
   parameter  int N     = 4,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     elig,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

   logic             found_s;
   logic [PTR_W:0]   sum_s;
   logic [PTR_W-1:0] idx_s;

   // Walk the N candidate positions in priority order; the first eligible one wins.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      sum_s   = '0;
      idx_s   = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k never exceeds 2N-2, so one conditional subtract is a full modulo.
         sum_s = {1'b0, ptr} + (PTR_W + 1)'(k);
         if (sum_s >= N_W) begin
            idx_s = PTR_W'(sum_s - N_W);
         end else begin
            idx_s = PTR_W'(sum_s);
         end
         if (elig[idx_s] && !found_s) begin
            grant[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            // lower-priority or ineligible position: leave grant untouched
         end
      end
   end

endmodule

// File: rtl/emesh_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// emesh_fifo_arbiter
// Arbitrates N emesh transaction sources onto the write port of the async
// emesh FIFO, entirely in the FIFO write-clock domain. One requester is
// granted per cycle; the winner's fields are captured in a single output
// register that drives the FIFO. The FIFO programmable-full flag blocks all
// grants (the FIFO threshold must leave 2 free entries for the registered
// transaction still in flight).
//
// Build option:
//   EMESH_ARB_RR_EN  defined   -> round-robin, ptr rotates to (winner+1) mod N
//                    undefined -> fixed priority, lowest index wins (ptr = 0)
//
// Ports:
//   clk, reset            write clock, synchronous active-high reset
//   req_access/write      per-requester valid / write flag          [N]
//   req_datamode          per-requester datamode                    [2N]
//   req_ctrlmode          per-requester ctrlmode                    [4N]
//   req_dstaddr/data/srcaddr per-requester 32-bit fields            [32N]
//   req_wait              per-requester stall, combinational        [N]
//   fifo_progfull         FIFO programmable-full, blocks all grants
//   emesh_*_out           registered packet toward the FIFO write port
// ----------------------------------------------------------------------------
module emesh_fifo_arbiter
   import emesh_pkg::*;
#(
   parameter  int N     = 4,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_access,
   input  logic [N-1:0]    req_write,
   input  logic [2*N-1:0]  req_datamode,
   input  logic [4*N-1:0]  req_ctrlmode,
   input  logic [32*N-1:0] req_dstaddr,
   input  logic [32*N-1:0] req_data,
   input  logic [32*N-1:0] req_srcaddr,
   output logic [N-1:0]    req_wait,
   input  logic            fifo_progfull,
   output logic            emesh_access_out,
   output logic            emesh_write_out,
   output logic [1:0]      emesh_datamode_out,
   output logic [3:0]      emesh_ctrlmode_out,
   output logic [31:0]     emesh_dstaddr_out,
   output logic [31:0]     emesh_data_out,
   output logic [31:0]     emesh_srcaddr_out
);

   logic [N-1:0]     elig_s;
   logic [N-1:0]     grant_s;
   logic [PTR_W-1:0] ptr_s;
   emesh_packet_t    mux_pkt_s;
   emesh_packet_t    out_r;

   // Reset and progfull suppress eligibility, so every active requester waits.
   assign elig_s   = req_access & {N{~fifo_progfull & ~reset}};
   assign req_wait = req_access & ~grant_s;

   arb_rr #(.N(N)) u_arb (
      .elig  (elig_s),
      .ptr   (ptr_s),
      .grant (grant_s)
   );

   // One-hot field mux; access in the muxed packet doubles as "some grant".
   always_comb begin
      mux_pkt_s = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_s[i]) begin
            mux_pkt_s.access   = 1'b1;
            mux_pkt_s.write    = req_write[i];
            mux_pkt_s.datamode = req_datamode[2*i +: 2];
            mux_pkt_s.ctrlmode = req_ctrlmode[4*i +: 4];
            mux_pkt_s.dstaddr  = req_dstaddr[32*i +: 32];
            mux_pkt_s.data     = req_data[32*i +: 32];
            mux_pkt_s.srcaddr  = req_srcaddr[32*i +: 32];
         end else begin
            // not granted: contributes nothing to the mux
         end
      end
   end

   // Output register: load the winner, otherwise drop the strobe and hold the fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_r <= '0;
      end else if (mux_pkt_s.access) begin
         out_r <= mux_pkt_s;
      end else begin
         out_r.access <= 1'b0;
      end
   end

   assign emesh_access_out   = out_r.access;
   assign emesh_write_out    = out_r.write;
   assign emesh_datamode_out = out_r.datamode;
   assign emesh_ctrlmode_out = out_r.ctrlmode;
   assign emesh_dstaddr_out  = out_r.dstaddr;
   assign emesh_data_out     = out_r.data;
   assign emesh_srcaddr_out  = out_r.srcaddr;

`ifdef EMESH_ARB_RR_EN
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W-1:0] ptr_nxt_s;

   // Priority moves to the position just after this cycle's winner.
   always_comb begin
      ptr_nxt_s = ptr_r;
      for (int i = 0; i < N; i++) begin
         if (grant_s[i]) begin
            ptr_nxt_s = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end else begin
            // no grant at this position: keep current candidate
         end
      end
   end

   // Priority pointer register; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= '0;
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   assign ptr_s = ptr_r;
`else
   assign ptr_s = '0;
`endif

endmodule

// File: tb/tb_emesh_fifo_arbiter.sv
// ----------------------------------------------------------------------------
// tb_emesh_fifo_arbiter
// Self-checking bench for emesh_fifo_arbiter (N = 4). A behavioural model
// keeps the "next favoured requester" as an integer and a queue of granted
// packets; it predicts req_wait and the registered output every cycle.
// Directed phases pin the model with literal expectations, then a random
// phase with protocol-obeying requesters, progfull and reset runs 10k cycles.
// The bench follows EMESH_ARB_RR_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_emesh_fifo_arbiter;

   localparam int N   = 4;
   localparam int PKW = 103;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_access;
   logic [N-1:0]    req_write;
   logic [2*N-1:0]  req_datamode;
   logic [4*N-1:0]  req_ctrlmode;
   logic [32*N-1:0] req_dstaddr;
   logic [32*N-1:0] req_data;
   logic [32*N-1:0] req_srcaddr;
   logic [N-1:0]    req_wait;
   logic            fifo_progfull;
   logic            emesh_access_out;
   logic            emesh_write_out;
   logic [1:0]      emesh_datamode_out;
   logic [3:0]      emesh_ctrlmode_out;
   logic [31:0]     emesh_dstaddr_out;
   logic [31:0]     emesh_data_out;
   logic [31:0]     emesh_srcaddr_out;

   emesh_fifo_arbiter #(.N(N)) dut (
      .clk                (clk),
      .reset              (reset),
      .req_access         (req_access),
      .req_write          (req_write),
      .req_datamode       (req_datamode),
      .req_ctrlmode       (req_ctrlmode),
      .req_dstaddr        (req_dstaddr),
      .req_data           (req_data),
      .req_srcaddr        (req_srcaddr),
      .req_wait           (req_wait),
      .fifo_progfull      (fifo_progfull),
      .emesh_access_out   (emesh_access_out),
      .emesh_write_out    (emesh_write_out),
      .emesh_datamode_out (emesh_datamode_out),
      .emesh_ctrlmode_out (emesh_ctrlmode_out),
      .emesh_dstaddr_out  (emesh_dstaddr_out),
      .emesh_data_out     (emesh_data_out),
      .emesh_srcaddr_out  (emesh_srcaddr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int              rr_start = 0;   // requester searched first
   int              xfer_idx = -1;  // requester that transferred at the last edge
   logic            model_on = 1'b0;
   logic            after_rst = 1'b0;
   logic            exp_acc = 1'b0;
   logic [PKW-1:0]  exp_pkt = '0;
   logic [PKW-1:0]  sb_q [$];
   int              wcnt [N];
   int              wmax = 0;

   // stimulus state
   logic [N-1:0]    want = '0;
   logic            rst_d = 1'b1;
   logic            pf_d = 1'b0;
   int unsigned     seq [N];
   logic [3:0]      p3_exp [5];

   task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [PKW-1:0] in_pkt(input int i);
      return {req_srcaddr[32*i +: 32], req_data[32*i +: 32], req_dstaddr[32*i +: 32],
              req_ctrlmode[4*i +: 4], req_datamode[2*i +: 2], req_write[i]};
   endfunction

   function automatic logic [PKW-1:0] dut_pkt();
      return {emesh_srcaddr_out, emesh_data_out, emesh_dstaddr_out,
              emesh_ctrlmode_out, emesh_datamode_out, emesh_write_out};
   endfunction

   // Winner = first requester with access, scanning upward from rr_start.
   function automatic int model_grant(input logic [N-1:0] acc, input logic pf, input logic rst);
      if (pf || rst) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (rr_start + k) % N;
         if (acc[i]) return i;
      end
      return -1;
   endfunction

   task automatic new_txn(input int i);
      req_access[i]            = 1'b1;
      req_write[i]             = 1'($urandom);
      req_datamode[2*i +: 2]   = 2'($urandom);
      req_ctrlmode[4*i +: 4]   = 4'($urandom);
      req_dstaddr[32*i +: 32]  = 32'h8000_0000 + seq[i];
      req_data[32*i +: 32]     = $urandom;
      req_srcaddr[32*i +: 32]  = {4'(i), 28'(seq[i])};
      seq[i]++;
   endtask

   // Advance one cycle; requesters hold while stalled, else follow want.
   task automatic step();
      @(posedge clk);
      #1;
      reset         = rst_d;
      fifo_progfull = pf_d;
      for (int i = 0; i < N; i++) begin
         if (!req_access[i] || xfer_idx == i) begin
            if (want[i]) new_txn(i);
            else req_access[i] = 1'b0;
         end
      end
   endtask

   // Model update at each active edge, from the inputs presented before it.
   initial begin
      forever begin
         int g;
         @(posedge clk);
         g = model_grant(req_access, fifo_progfull, reset);
         xfer_idx  = g;
         after_rst = 1'b0;
         if (reset) begin
            exp_acc   = 1'b0;
            exp_pkt   = '0;
            rr_start  = 0;
            model_on  = 1'b1;
            after_rst = 1'b1;
            for (int i = 0; i < N; i++) wcnt[i] = 0;
         end else if (g >= 0) begin
            exp_acc = 1'b1;
            exp_pkt = in_pkt(g);
            sb_q.push_back(in_pkt(g));
`ifdef EMESH_ARB_RR_EN
            rr_start = (g + 1) % N;
`endif
            for (int i = 0; i < N; i++) begin
               if (i == g) wcnt[i] = 0;
               else if (req_access[i]) begin
                  wcnt[i]++;
                  if (wcnt[i] > wmax) wmax = wcnt[i];
               end
            end
         end else begin
            exp_acc = 1'b0;
         end
      end
   end

   // Every-cycle comparison on the falling edge.
   initial begin
      forever begin
         int g;
         logic [N-1:0] ew;
         @(negedge clk);
         if (model_on) begin
            g  = model_grant(req_access, fifo_progfull, reset);
            ew = req_access;
            if (g >= 0) ew[g] = 1'b0;
            chk("req_wait", req_wait, ew);
            chk("access_out", emesh_access_out, exp_acc);
            if (exp_acc || after_rst) chk("fields_out", dut_pkt(), exp_pkt);
            if (emesh_access_out === 1'b1) begin
               chk("sb_has_entry", sb_q.size() != 0, 1'b1);
               if (sb_q.size() != 0) chk("sb_order", dut_pkt(), sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1'b1; fifo_progfull = 1'b0; req_access = '0; req_write = '0;
      req_datamode = '0; req_ctrlmode = '0; req_dstaddr = '0; req_data = '0;
      req_srcaddr = '0;
      for (int i = 0; i < N; i++) begin seq[i] = 0; wcnt[i] = 0; end
`ifdef EMESH_ARB_RR_EN
      p3_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
`else
      p3_exp = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
`endif

      // reset state
      step(); step();
      @(negedge clk);
      chk("rst_access", emesh_access_out, 1'b0);
      chk("rst_dstaddr", emesh_dstaddr_out, 32'h0);

      // single requester 0, five back-to-back writes
      rst_d = 1'b0; want = 4'b0001; step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("p1_wait0", req_wait[0], 1'b0);
         if (k > 0) chk("p1_write", {emesh_access_out, emesh_dstaddr_out},
                        {1'b1, 32'h8000_0000 + 32'(k - 1)});
         if (k == 4) want = 4'b0000;
         step();
      end
      @(negedge clk);
      chk("p1_write_last", {emesh_access_out, emesh_dstaddr_out}, {1'b1, 32'h8000_0004});

      // all four requesters from ptr = 0
      rst_d = 1'b1; step(); rst_d = 1'b0; want = 4'b1111; step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("p2_wait", req_wait, p3_exp[k]);
         step();
      end
      want = 4'b0000; repeat (6) step();

      // requesters 1 and 3 with a 3-cycle progfull window
      rst_d = 1'b1; step(); rst_d = 1'b0; want = 4'b1010; step();
      @(negedge clk); step();
      @(negedge clk); pf_d = 1'b1; step();
      @(negedge clk); chk("pf_wait_a", req_wait, 4'b1010); chk("pf_trail", emesh_access_out, 1'b1); step();
      @(negedge clk); chk("pf_wait_b", req_wait, 4'b1010); chk("pf_idle_b", emesh_access_out, 1'b0); step();
      @(negedge clk); chk("pf_wait_c", req_wait, 4'b1010); chk("pf_idle_c", emesh_access_out, 1'b0);
      pf_d = 1'b0; step();
      @(negedge clk); chk("pf_resume_wait", req_wait, 4'b1000); chk("pf_idle_d", emesh_access_out, 1'b0); step();
      @(negedge clk); chk("pf_resume_out", {emesh_access_out, emesh_srcaddr_out[31:28]}, {1'b1, 4'd1});

      // reset while a transaction sits in the output register
      want = 4'b1111; step();
      @(negedge clk); chk("mr_busy", emesh_access_out, 1'b1);
      rst_d = 1'b1; step();
      @(negedge clk); chk("mr_wait_eq_access", req_wait, 4'b1111);
      step();
      @(negedge clk); chk("mr_access", emesh_access_out, 1'b0); chk("mr_fields", dut_pkt(), 103'd0);
      rst_d = 1'b0; step();
      @(negedge clk); chk("mr_ptr0", req_wait, 4'b1110);
      want = 4'b0000; repeat (6) step();

      // random traffic
      begin
         int act_pct;
         act_pct = 50;
         for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 1000 == 0) act_pct = $urandom_range(10, 100);
            for (int i = 0; i < N; i++) want[i] = ($urandom_range(0, 99) < act_pct);
            pf_d  = ($urandom_range(0, 99) < 8);
            rst_d = ($urandom_range(0, 999) < 3);
            step();
         end
      end
      want = 4'b0000; pf_d = 1'b0; rst_d = 1'b0;
      repeat (10) step();
      @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
`ifdef EMESH_ARB_RR_EN
      chk("rr_max_wait", wmax <= N - 1, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
